// File: rtl/watch_pkg.sv
// Shared encodings for the watch control units: set-mode state codes,
// field-select codes and small helpers mapping between them.
package watch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t NORMAL   = 2'b00;
  localparam state_t SET_HOUR = 2'b01;
  localparam state_t SET_MIN  = 2'b10;
  localparam state_t SET_SEC  = 2'b11;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HOUR = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_SEC  = 2'b11;

  // Mode button walks NORMAL -> HOUR -> MIN -> SEC -> NORMAL.
  function automatic state_t next_field(input state_t s);
    case (s)
      NORMAL:   return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_SEC;
      SET_SEC:  return NORMAL;
      default:  return NORMAL;
    endcase
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      SET_HOUR: return SEL_HOUR;
      SET_MIN:  return SEL_MIN;
      SET_SEC:  return SEL_SEC;
      default:  return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Per-key press detector: one pulse on a clean rising edge and, when
// CLOCK_SET_REPEAT_EN is defined, tick-based auto-repeat while held.
module btn_repeat #(
  parameter int REPEAT_DLY_MS = 600,
  parameter int REPEAT_MS     = 150
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  input  logic i_block,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_pulse
);

  logic key_q;
  logic rise_s;

  assign rise_s = i_key & ~key_q;

  // Previous key level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_q <= 1'b0;
    else       key_q <= i_key;
  end

`ifdef CLOCK_SET_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY_MS > REPEAT_MS) ? REPEAT_DLY_MS : REPEAT_MS;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, thr_s;
  logic armed_q, armed_d, rep_q, rep_d, pulse_s;

  // armed only after an accepted edge, so a held key never repeats across a clear.
  always_comb begin
    thr_s   = rep_q ? CNT_W'(REPEAT_MS) : CNT_W'(REPEAT_DLY_MS);
    cnt_d   = cnt_q;
    armed_d = armed_q;
    rep_d   = rep_q;
    pulse_s = 1'b0;
    if (i_clear || i_block || !i_key) begin
      cnt_d   = {CNT_W{1'b0}};
      rep_d   = 1'b0;
      armed_d = 1'b0;
    end else if (rise_s) begin
      pulse_s = 1'b1;
      armed_d = 1'b1;
      cnt_d   = {CNT_W{1'b0}};
      rep_d   = 1'b0;
    end else if (armed_q && i_tick) begin
      if ((cnt_q + CNT_W'(1)) == thr_s) begin
        pulse_s = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
        rep_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Repeat counter and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      armed_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      rep_q   <= rep_d;
    end
  end

  assign o_pulse = pulse_s;
`else
  logic unused_s;

  assign unused_s = ^{i_tick, 32'(REPEAT_DLY_MS), 32'(REPEAT_MS)};
  assign o_pulse  = rise_s & ~i_block & ~i_clear;
`endif

endmodule

// File: rtl/clock_set_cu.sv
// Time-setting control unit: field select FSM, inc/dec pulses, blink and
// inactivity timeout. Auto-repeat is enabled by defining CLOCK_SET_REPEAT_EN.
module clock_set_cu
  import watch_pkg::*;
#(
  parameter int TIMEOUT_MS    = 10000,
  parameter int BLINK_MS      = 500,
  parameter int REPEAT_DLY_MS = 600,
  parameter int REPEAT_MS     = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_ms,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_set_en,
  output logic [1:0] o_sel,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_blink_on
);

  localparam int TO_W = $clog2(TIMEOUT_MS + 1);
  localparam int BL_W = $clog2(BLINK_MS + 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            set_en_q, set_en_d, inc_q, inc_d, dec_q, dec_d, blink_q, blink_d;
  logic            in_set_s, key_any_s, timeout_s, rpt_clear_s, up_pulse_s, dn_pulse_s;

  assign in_set_s    = (state_q != NORMAL);
  assign key_any_s   = i_btn_up | i_btn_down;
  assign timeout_s   = in_set_s & i_tick_ms & ~i_btn_mode & ~key_any_s &
                       (to_cnt_q == TO_W'(TIMEOUT_MS - 1));
  assign rpt_clear_s = ~in_set_s | i_btn_mode | timeout_s;

  btn_repeat #(.REPEAT_DLY_MS(REPEAT_DLY_MS), .REPEAT_MS(REPEAT_MS)) u_up (
    .clk(clk), .reset(reset), .i_key(i_btn_up), .i_block(i_btn_down),
    .i_clear(rpt_clear_s), .i_tick(i_tick_ms), .o_pulse(up_pulse_s)
  );

  btn_repeat #(.REPEAT_DLY_MS(REPEAT_DLY_MS), .REPEAT_MS(REPEAT_MS)) u_dn (
    .clk(clk), .reset(reset), .i_key(i_btn_down), .i_block(i_btn_up),
    .i_clear(rpt_clear_s), .i_tick(i_tick_ms), .o_pulse(dn_pulse_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  // Next state: mode button has priority over timeout.
  always_comb begin
    state_d = state_q;
    if (i_btn_mode)     state_d = next_field(state_q);
    else if (timeout_s) state_d = NORMAL;
    else                state_d = state_q;
  end

  // Outputs and tick counters, computed from the next state so they register with it.
  always_comb begin
    set_en_d = (state_d != NORMAL);
    sel_d    = sel_of(state_d);
    inc_d    = up_pulse_s & in_set_s & ~i_btn_mode & ~i_btn_down;
    dec_d    = dn_pulse_s & in_set_s & ~i_btn_mode & ~i_btn_up;

    to_cnt_d = to_cnt_q;
    if (~in_set_s || i_btn_mode || key_any_s || timeout_s) to_cnt_d = {TO_W{1'b0}};
    else if (i_tick_ms)                                     to_cnt_d = to_cnt_q + TO_W'(1);
    else                                                    to_cnt_d = to_cnt_q;

    bl_cnt_d = bl_cnt_q;
    blink_d  = blink_q;
    if ((state_d == NORMAL) || (state_d != state_q) || key_any_s) begin
      blink_d  = 1'b1;
      bl_cnt_d = {BL_W{1'b0}};
    end else if (i_tick_ms) begin
      if (bl_cnt_q == BL_W'(BLINK_MS - 1)) begin
        blink_d  = ~blink_q;
        bl_cnt_d = {BL_W{1'b0}};
      end else begin
        blink_d  = blink_q;
        bl_cnt_d = bl_cnt_q + BL_W'(1);
      end
    end else begin
      blink_d  = blink_q;
      bl_cnt_d = bl_cnt_q;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= {TO_W{1'b0}};
      bl_cnt_q <= {BL_W{1'b0}};
      sel_q    <= SEL_NONE;
      set_en_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      blink_q  <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_d;
      bl_cnt_q <= bl_cnt_d;
      sel_q    <= sel_d;
      set_en_q <= set_en_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      blink_q  <= blink_d;
    end
  end

  assign o_set_en   = set_en_q;
  assign o_sel      = sel_q;
  assign o_inc      = inc_q;
  assign o_dec      = dec_q;
  assign o_blink_on = blink_q;

endmodule

// File: tb/tb_clock_set_cu.sv
// Directed self-checking bench for clock_set_cu (small timing parameters,
// tick every 4 clocks). Expectations follow CLOCK_SET_REPEAT_EN if defined.
module tb_clock_set_cu;

`ifdef CLOCK_SET_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, i_tick_ms, i_btn_mode, i_btn_up, i_btn_down;
  logic       o_set_en, o_inc, o_dec, o_blink_on;
  logic [1:0] o_sel;

  int errors = 0, checks = 0;
  int inc_seen = 0, dec_seen = 0, blink_low = 0;
  int snap_i, snap_d, snap_b;

  clock_set_cu #(.TIMEOUT_MS(20), .BLINK_MS(5), .REPEAT_DLY_MS(10), .REPEAT_MS(3)) dut (
    .clk(clk), .reset(reset), .i_tick_ms(i_tick_ms), .i_btn_mode(i_btn_mode),
    .i_btn_up(i_btn_up), .i_btn_down(i_btn_down), .o_set_en(o_set_en),
    .o_sel(o_sel), .o_inc(o_inc), .o_dec(o_dec), .o_blink_on(o_blink_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs already applied, sample 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (o_inc === 1'b1) inc_seen++;
    if (o_dec === 1'b1) dec_seen++;
    if (o_blink_on === 1'b0) blink_low++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_tick_ms = 1'b1; cyc();
      i_tick_ms = 1'b0; cyc(); cyc(); cyc();
    end
  endtask

  task automatic mode_pulse();
    i_btn_mode = 1'b1; cyc();
    i_btn_mode = 1'b0; cyc();
  endtask

  initial begin
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    reset = 1'b1; i_tick_ms = 1'b0; i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
    #1; cyc(); cyc();
    chk("rst_sel", 32'(o_sel), 32'd0);
    chk("rst_set_en", 32'(o_set_en), 32'd0);
    chk("rst_inc", 32'(o_inc), 32'd0);
    chk("rst_dec", 32'(o_dec), 32'd0);
    chk("rst_blink", 32'(o_blink_on), 32'd1);
    reset = 1'b0; cyc();

    // Mode walk through all fields and back.
    snap_i = inc_seen; snap_d = dec_seen;
    for (int k = 0; k < 4; k++) begin
      i_btn_mode = 1'b1; cyc();
      chk("walk_sel", 32'(o_sel), 32'(exp_sel[k]));
      chk("walk_set_en", 32'(o_set_en), (k < 3) ? 32'd1 : 32'd0);
      i_btn_mode = 1'b0; cyc();
    end
    chk("walk_no_inc", 32'(inc_seen - snap_i), 32'd0);
    chk("walk_no_dec", 32'(dec_seen - snap_d), 32'd0);

    // SET_MIN: tap up across 2 ticks.
    mode_pulse(); mode_pulse();
    chk("tap_sel", 32'(o_sel), 32'd2);
    snap_i = inc_seen; snap_d = dec_seen;
    i_btn_up = 1'b1; cyc();
    chk("tap_inc_edge", 32'(o_inc), 32'd1);
    chk("tap_dec_edge", 32'(o_dec), 32'd0);
    cyc();
    chk("tap_inc_width", 32'(o_inc), 32'd0);
    ticks(2);
    i_btn_up = 1'b0; cyc();
    chk("tap_inc_count", 32'(inc_seen - snap_i), 32'd1);
    chk("tap_dec_count", 32'(dec_seen - snap_d), 32'd0);

    // SET_HOUR: hold down for 20 ticks.
    mode_pulse(); mode_pulse(); mode_pulse();
    chk("hold_sel", 32'(o_sel), 32'd1);
    snap_d = dec_seen; snap_b = blink_low;
    i_btn_down = 1'b1; cyc();
    chk("hold_dec_press", 32'(o_dec), 32'd1);
    for (int t = 1; t <= 20; t++) begin
      i_tick_ms = 1'b1; cyc();
      chk("hold_dec_tick", 32'(o_dec),
          (RPT && t >= 10 && ((t - 10) % 3) == 0) ? 32'd1 : 32'd0);
      i_tick_ms = 1'b0; cyc(); cyc(); cyc();
    end
    i_btn_down = 1'b0; cyc();
    chk("hold_dec_count", 32'(dec_seen - snap_d), RPT ? 32'd5 : 32'd1);
    chk("hold_blink_on", 32'(blink_low - snap_b), 32'd0);

    // SET_SEC: idle until timeout, checking blink phase each tick.
    mode_pulse(); mode_pulse();
    chk("idle_sel", 32'(o_sel), 32'd3);
    for (int t = 1; t <= 20; t++) begin
      i_tick_ms = 1'b1; cyc();
      if (t < 20) begin
        chk("idle_blink", 32'(o_blink_on), (((t / 5) % 2) == 0) ? 32'd1 : 32'd0);
        chk("idle_still_set", 32'(o_sel), 32'd3);
      end else begin
        chk("timeout_sel", 32'(o_sel), 32'd0);
        chk("timeout_set_en", 32'(o_set_en), 32'd0);
        chk("timeout_blink", 32'(o_blink_on), 32'd1);
      end
      i_tick_ms = 1'b0; cyc(); cyc(); cyc();
    end

    // SET_MIN: both keys rise together.
    mode_pulse(); mode_pulse();
    snap_i = inc_seen; snap_d = dec_seen;
    i_btn_up = 1'b1; i_btn_down = 1'b1; cyc();
    chk("both_inc", 32'(o_inc), 32'd0);
    chk("both_dec", 32'(o_dec), 32'd0);
    ticks(12);
    i_btn_up = 1'b0; i_btn_down = 1'b0; cyc();
    chk("both_inc_count", 32'(inc_seen - snap_i), 32'd0);
    chk("both_dec_count", 32'(dec_seen - snap_d), 32'd0);

    // Mode coincident with up rise: advance, no pulse, no repeat while held.
    snap_i = inc_seen;
    i_btn_mode = 1'b1; i_btn_up = 1'b1; cyc();
    chk("prio_sel", 32'(o_sel), 32'd3);
    chk("prio_inc", 32'(o_inc), 32'd0);
    i_btn_mode = 1'b0;
    ticks(12);
    i_btn_up = 1'b0; cyc();
    chk("prio_inc_count", 32'(inc_seen - snap_i), 32'd0);

    // SET_HOUR: reset while holding up mid-repeat.
    mode_pulse(); mode_pulse();
    chk("rr_sel", 32'(o_sel), 32'd1);
    i_btn_up = 1'b1; cyc();
    chk("rr_inc_press", 32'(o_inc), 32'd1);
    ticks(11);
    reset = 1'b1; #1;
    chk("rr_async_sel", 32'(o_sel), 32'd0);
    chk("rr_async_set_en", 32'(o_set_en), 32'd0);
    chk("rr_async_inc", 32'(o_inc), 32'd0);
    chk("rr_async_dec", 32'(o_dec), 32'd0);
    chk("rr_async_blink", 32'(o_blink_on), 32'd1);
    cyc(); cyc();
    snap_i = inc_seen;
    reset = 1'b0; cyc();
    chk("rr_release_inc", 32'(o_inc), 32'd0);
    ticks(12);
    chk("rr_normal_inc_count", 32'(inc_seen - snap_i), 32'd0);
    i_btn_mode = 1'b1; cyc();
    chk("rr_enter_sel", 32'(o_sel), 32'd1);
    chk("rr_enter_inc", 32'(o_inc), 32'd0);
    i_btn_mode = 1'b0;
    ticks(12);
    chk("rr_held_inc_count", 32'(inc_seen - snap_i), 32'd0);
    i_btn_up = 1'b0; cyc();
    i_btn_up = 1'b1; cyc();
    chk("rr_fresh_inc", 32'(o_inc), 32'd1);
    i_btn_up = 1'b0; cyc();
    chk("rr_fresh_width", 32'(o_inc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_cu.md
Name: clock_set_cu

Overview:
- Control unit for time-setting mode of the watch datapath (hour/min/sec counters + FND display).
- Consumes debounced buttons and a 1 ms tick; sequences field selection; issues single-cycle increment/decrement pulses (with auto-repeat); drives field-blink enable; exits to normal on inactivity timeout.
- Sits beside stopwatch_cu; its outputs feed the watch counter datapath and display mux.

Parameters:
- TIMEOUT_MS, 10000, inactivity ticks in any SET state before forced return to NORMAL
- BLINK_MS, 500, ticks per half-period of the blink toggle
- REPEAT_DLY_MS, 600, hold ticks before the first auto-repeat pulse
- REPEAT_MS, 150, ticks between subsequent auto-repeat pulses

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_tick_ms  input  1  one-clk enable pulse every 1 ms
- i_btn_mode  input  1  debounced one-clk press pulse; advances field
- i_btn_up  input  1  debounced level, high while held
- i_btn_down  input  1  debounced level, high while held
- o_set_en  output  1  high in any SET state; datapath stops normal counting
- o_sel  output  2  0=none, 1=hour, 2=min, 3=sec
- o_inc  output  1  one-clk increment pulse for the selected field
- o_dec  output  1  one-clk decrement pulse for the selected field
- o_blink_on  output  1  1 = show selected field digits, 0 = blank them

Behaviour:
- One clock (clk); reset is asynchronous and active-high. All outputs are registered.
- Reset values: state NORMAL; o_set_en=0, o_sel=0, o_inc=0, o_dec=0, o_blink_on=1; all counters 0.
- States: NORMAL, SET_HOUR, SET_MIN, SET_SEC.
  - i_btn_mode: NORMAL→SET_HOUR→SET_MIN→SET_SEC→NORMAL.
  - Timeout: any SET state→NORMAL.
- o_sel tracks the state: 0/1/2/3. o_set_en = (state != NORMAL).
- Up/down edge detect, SET states only:
  - Rise of i_btn_up with i_btn_down low → o_inc high for exactly one clk, first visible after the edge that samples the rise. o_dec is symmetric.
  - Up and down both high → no pulses; repeat counter held at 0.
  - In NORMAL, up/down are ignored and no pulses are issued.
- Mode priority: i_btn_mode in the same cycle as an up/down rise → state advances, no inc/dec pulse.
- Auto-repeat: while one key is held alone, count i_tick_ms.
  - At REPEAT_DLY_MS ticks, issue a pulse; then one pulse every REPEAT_MS ticks.
  - Release, or pressing the other key, clears the counter.
  - A state change clears it and suppresses pulses until a fresh rising edge.
- Timeout counter:
  - Counts i_tick_ms in SET states.
  - Cleared by i_btn_mode, by i_btn_up or i_btn_down high, and on entering a SET state.
  - On the tick that reaches TIMEOUT_MS → NORMAL next edge.
- Blink:
  - On entering any SET state: o_blink_on=1 and blink counter=0.
  - Toggles every BLINK_MS ticks.
  - Forced to 1 while up or down is held.
  - Returns to 1 in NORMAL.
- Counter widths: $clog2(param+1). All comparisons are on tick-qualified cycles only.
- Reset mid-set: immediate NORMAL, all pulses and counters cleared.

Optional Feature:
- Macro CLOCK_SET_REPEAT_EN.
  - Defined: auto-repeat as above.
  - Undefined: only one pulse per rising edge. Repeat counter and REPEAT_* parameters are unused (parameters kept for port/param compatibility). Holding a key still clears the timeout and forces o_blink_on=1.

Decomposition:
- Shared package watch_pkg holds:
  - state encoding localparams (NORMAL=2'b00, SET_HOUR=2'b01, SET_MIN=2'b10, SET_SEC=2'b11)
  - o_sel codes SEL_NONE/HOUR/MIN/SEC
- Natural sub-module btn_repeat, instantiated twice (up, down).
  - Inputs: key level, block, clear, tick.
  - Output: one-clk pulse covering edge detect + repeat counter.
  - The top-level FSM gates pulses by state and both-keys.

Test Plan (sim params: TIMEOUT_MS=20, BLINK_MS=5, REPEAT_DLY_MS=10, REPEAT_MS=3; tick every 4 clk):
- Reset then 4 i_btn_mode pulses → o_sel 1,2,3,0; o_set_en 1,1,1,0; no o_inc/o_dec.
- SET_MIN, tap i_btn_up for 2 ticks → exactly one o_inc, one clk wide, one edge after the rise; o_dec stays 0.
- SET_HOUR, hold i_btn_down 20 ticks → o_dec pulses at press, tick 10, 13, 16, 19 (5 total); o_blink_on=1 throughout. Undefined macro → 1 pulse.
- SET_SEC, idle 20 ticks → back to NORMAL (o_sel=0, o_set_en=0) on the 20th tick edge. o_blink_on pattern 1(5 ticks),0(5),1,0 before exit.
- Up and down rise same cycle in SET_MIN → no pulses. Mode pulse coincident with up rise → o_sel advances, no o_inc.
- Assert reset while holding up in SET_HOUR mid-repeat → all outputs to reset values asynchronously. After release, no pulse until a new up rise in a SET state.
